rom_access_arbiter: RTL and testbench

- Shares the single-read-port image ROM between two requesters.
  - The display pixel-fetch path is hard real-time and is never stalled.
  - The auxiliary requester (sprite/game-logic update engine) is best-effort.
- Issues one ROM read per cycle and tracks in-flight reads through a tag pipeline matched to the ROM latency.
- Routes each returned word to the requester that issued it, with a one-cycle valid strobe.
- Sits between the VGA controller's pixel-address logic and ImageRom, in the vga_clk domain.

---
 rtl/rom_access_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_rom_access_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
// Shares the single-read-port ImageRom between the hard real-time display
// pixel-fetch path and a best-effort auxiliary requester, in the vga_clk domain.
// The display always wins; the aux requester gets free slots, limited to
// AUX_BURST consecutive grants before one forced idle slot. In-flight reads are
// tracked by an RD_LAT-deep {valid, owner} tag pipeline, and each returned word
// is steered to its requester one cycle after it leaves the ROM.
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   blank               1 = outside active video
//   disp_req/disp_addr  display read request (never stalled) and address
//   disp_data/valid     registered display return data and one-cycle strobe
//   aux_req/aux_addr    aux request (held until granted) and address
//   aux_gnt             combinational: aux read issued this cycle
//   aux_data/valid      registered aux return data and one-cycle strobe
//   rom_addr/rom_en     combinational ROM read command (addr holds when idle)
//   rom_data            ROM read data, RD_LAT cycles after rom_en
//
// Optional build macro ROM_ARB_STARVE_CNT_EN adds aux_starve_cnt (saturating
// count of cycles aux waited without a grant) and aux_starve_max (highest
// value of that count since reset).
module rom_access_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned AUX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_data,
  output logic              aux_valid,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data
`ifdef ROM_ARB_STARVE_CNT_EN
  ,
  output logic [15:0]       aux_starve_cnt,
  output logic [15:0]       aux_starve_max
`endif
);

  localparam int unsigned BCNT_W = $clog2(AUX_BURST + 1);
  localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(AUX_BURST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DISP = 2'd1,
    S_AUX  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   burst_q, burst_d;
  logic                aux_elig;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [RD_LAT-1:0]   tag_v;
  logic [RD_LAT-1:0]   tag_aux;

  // Aux may use any cycle the display leaves free, until the burst limit is hit
  assign aux_elig = (burst_q < BURST_MAX) & (blank | ~disp_req);

  // State and burst counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  // Next state and burst count; a grant not following an aux cycle starts a new burst
  always_comb begin
    state_d = S_IDLE;
    burst_d = '0;
    if (disp_req) begin
      state_d = S_DISP;
    end else if (aux_req && aux_elig) begin
      state_d = S_AUX;
    end
    if (aux_gnt) begin
      if (state_q != S_AUX) begin
        burst_d = BCNT_W'(1);
      end else if (burst_q < BURST_MAX) begin
        burst_d = burst_q + BCNT_W'(1);
      end else begin
        burst_d = BURST_MAX;
      end
    end
  end

  // ROM command: display first, aux on eligible free cycles, address held when idle
  always_comb begin
    aux_gnt  = aux_req & ~disp_req & aux_elig;
    rom_en   = disp_req | aux_gnt;
    rom_addr = rom_addr_q;
    if (disp_req) begin
      rom_addr = disp_addr;
    end else if (aux_gnt) begin
      rom_addr = aux_addr;
    end
  end

  // Last issued address, so rom_addr stays put on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
    end else if (rom_en) begin
      rom_addr_q <= rom_addr;
    end
  end

  // Tag pipeline: one {valid, owner} entry per cycle, owner 1 = aux
  if (RD_LAT > 1) begin : g_tag_shift
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_v   <= '0;
        tag_aux <= '0;
      end else begin
        tag_v   <= {tag_v[RD_LAT-2:0], rom_en};
        tag_aux <= {tag_aux[RD_LAT-2:0], ~disp_req};
      end
    end
  end else begin : g_tag_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_v   <= '0;
        tag_aux <= '0;
      end else begin
        tag_v   <= rom_en;
        tag_aux <= ~disp_req;
      end
    end
  end

  // Return path: steer the word leaving the ROM to its owner; other output holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data  <= '0;
      disp_valid <= 1'b0;
      aux_data   <= '0;
      aux_valid  <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      aux_valid  <= 1'b0;
      if (tag_v[RD_LAT-1]) begin
        if (tag_aux[RD_LAT-1]) begin
          aux_data  <= rom_data;
          aux_valid <= 1'b1;
        end else begin
          disp_data  <= rom_data;
          disp_valid <= 1'b1;
        end
      end
    end
  end

`ifdef ROM_ARB_STARVE_CNT_EN
  logic [15:0] starve_d;

  // Cycles the aux requester has waited since its last grant, saturating
  always_comb begin
    starve_d = aux_starve_cnt;
    if (aux_gnt) begin
      starve_d = '0;
    end else if (aux_req && (aux_starve_cnt != 16'hFFFF)) begin
      starve_d = aux_starve_cnt + 16'd1;
    end
  end

  // Starvation count and its high-water mark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aux_starve_cnt <= '0;
      aux_starve_max <= '0;
    end else begin
      aux_starve_cnt <= starve_d;
      if (starve_d > aux_starve_max) begin
        aux_starve_max <= starve_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share the
// same request stimulus, each with its own ROM model. A reference model of the
// grant rules and a queue of expected returns are checked every cycle, plus a
// vector table and hand-written corner-case sequences.
module tb_rom_access_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 24;
  localparam int unsigned AB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          blank = 1'b0;
  logic          disp_req = 1'b0;
  logic          aux_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [AW-1:0] aux_addr = '0;

  logic [DW-1:0] d1_data, a1_data, r1_data, d3_data, a3_data, r3_data;
  logic          d1_valid, a1_valid, a1_gnt, r1_en;
  logic          d3_valid, a3_valid, a3_gnt, r3_en;
  logic [AW-1:0] r1_addr, r3_addr;
`ifdef ROM_ARB_STARVE_CNT_EN
  logic [15:0]   s1_cnt, s1_max, s3_cnt, s3_max;
`endif

  always #5 clk = ~clk;

  rom_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .AUX_BURST(AB)) u1 (
    .clk(clk), .rst_n(rst_n), .blank(blank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(d1_data), .disp_valid(d1_valid),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(a1_gnt), .aux_data(a1_data),
    .aux_valid(a1_valid), .rom_addr(r1_addr), .rom_en(r1_en), .rom_data(r1_data)
`ifdef ROM_ARB_STARVE_CNT_EN
    , .aux_starve_cnt(s1_cnt), .aux_starve_max(s1_max)
`endif
  );

  rom_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .AUX_BURST(AB)) u3 (
    .clk(clk), .rst_n(rst_n), .blank(blank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(d3_data), .disp_valid(d3_valid),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(a3_gnt), .aux_data(a3_data),
    .aux_valid(a3_valid), .rom_addr(r3_addr), .rom_en(r3_en), .rom_data(r3_data)
`ifdef ROM_ARB_STARVE_CNT_EN
    , .aux_starve_cnt(s3_cnt), .aux_starve_max(s3_max)
`endif
  );

  // ROM contents: a fixed hash of the address
  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a * 32'h0019_660D + 32'h3C6E_F35F;
    return t[31:8];
  endfunction

  logic [DW-1:0] rp1;
  logic [DW-1:0] rp3 [3];
  always @(posedge clk) begin
    rp1    <= word(r1_addr);
    rp3[0] <= word(r3_addr);
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign r1_data = rp1;
  assign r3_data = rp3[2];

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    int            due;
    bit            aux;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          q1[$];
  ret_t          q3[$];
  int            cyc = 0;
  int unsigned   m_run = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_dd1 = '0, m_ad1 = '0, m_dd3 = '0, m_ad3 = '0;
  bit            m_gnt = 1'b0;
  int            m_starve = 0, m_smax = 0;

  // Samples of the outputs taken in the last step
  logic          o1_gnt, o1_en, o1_dv, o1_av, o3_dv, o3_av;
  logic [AW-1:0] o1_addr;
  logic [DW-1:0] o1_dd, o1_ad, o3_dd, o3_ad;
  int            o_starve = 0, o_smax = 0;

  task automatic chk_ret(input string nm, input bit hit, input ret_t h,
                         input logic dv, input logic av,
                         input logic [DW-1:0] dd, input logic [DW-1:0] ad,
                         inout logic [DW-1:0] edd, inout logic [DW-1:0] ead);
    if (hit) begin
      if (h.aux) ead = h.data;
      else       edd = h.data;
    end
    chk({nm, "_disp_valid"}, 32'(dv), 32'(hit && !h.aux));
    chk({nm, "_aux_valid"},  32'(av), 32'(hit && h.aux));
    chk({nm, "_disp_data"},  32'(dd), 32'(edd));
    chk({nm, "_aux_data"},   32'(ad), 32'(ead));
  endtask

  // One clock cycle: compare everything against the model at negedge, then advance it
  task automatic step();
    bit            eg, ee, hit;
    logic [AW-1:0] ea;
    ret_t          h;
    @(negedge clk);
    eg = aux_req && !disp_req && (m_run < AB) && (blank || !disp_req);
    ee = disp_req || eg;
    ea = disp_req ? disp_addr : (eg ? aux_addr : m_addr);
    o1_gnt = a1_gnt; o1_en = r1_en; o1_addr = r1_addr;
    o1_dv = d1_valid; o1_av = a1_valid; o1_dd = d1_data; o1_ad = a1_data;
    o3_dv = d3_valid; o3_av = a3_valid; o3_dd = d3_data; o3_ad = a3_data;
    chk("gnt1", 32'(a1_gnt), 32'(eg));
    chk("en1", 32'(r1_en), 32'(ee));
    chk("addr1", r1_addr, ea);
    chk("gnt3", 32'(a3_gnt), 32'(eg));
    chk("en3", 32'(r3_en), 32'(ee));
    chk("addr3", r3_addr, ea);
    h = '{due: 0, aux: 1'b0, data: '0};
    hit = (q1.size() != 0) && (q1[0].due == cyc);
    if (hit) h = q1.pop_front();
    chk_ret("lat1", hit, h, d1_valid, a1_valid, d1_data, a1_data, m_dd1, m_ad1);
    h = '{due: 0, aux: 1'b0, data: '0};
    hit = (q3.size() != 0) && (q3[0].due == cyc);
    if (hit) h = q3.pop_front();
    chk_ret("lat3", hit, h, d3_valid, a3_valid, d3_data, a3_data, m_dd3, m_ad3);
`ifdef ROM_ARB_STARVE_CNT_EN
    o_starve = int'(s1_cnt);
    o_smax = int'(s1_max);
    chk("starve1", 32'(s1_cnt), 32'(m_starve));
    chk("smax1", 32'(s1_max), 32'(m_smax));
    chk("starve3", 32'(s3_cnt), 32'(m_starve));
`endif
    @(posedge clk);
    if (ee) begin
      h.aux = !disp_req;
      h.data = word(ea);
      h.due = cyc + 2;
      q1.push_back(h);
      h.due = cyc + 4;
      q3.push_back(h);
      m_addr = ea;
    end
    m_run = eg ? m_run + 1 : 0;
    if (eg) m_starve = 0;
    else if (aux_req && m_starve < 65535) m_starve++;
    if (m_starve > m_smax) m_smax = m_starve;
    m_gnt = eg;
    cyc++;
    #1;
  endtask

  // Asynchronous reset: outputs must clear at once, model forgets in-flight reads
  task automatic do_reset();
    disp_req = 1'b0;
    aux_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_disp_valid", 32'(d1_valid | d3_valid), 32'd0);
    chk("rst_aux_valid", 32'(a1_valid | a3_valid), 32'd0);
    chk("rst_disp_data1", 32'(d1_data), 32'd0);
    chk("rst_aux_data1", 32'(a1_data), 32'd0);
    chk("rst_disp_data3", 32'(d3_data), 32'd0);
    chk("rst_aux_data3", 32'(a3_data), 32'd0);
    chk("rst_rom_en", 32'(r1_en | r3_en | a1_gnt | a3_gnt), 32'd0);
    chk("rst_rom_addr1", r1_addr, 32'd0);
    chk("rst_rom_addr3", r3_addr, 32'd0);
    q1.delete();
    q3.delete();
    m_run = 0; m_addr = '0; m_gnt = 1'b0;
    m_dd1 = '0; m_ad1 = '0; m_dd3 = '0; m_ad3 = '0;
    m_starve = 0; m_smax = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic          blank, dreq, areq;
    logic [AW-1:0] daddr, aaddr;
    logic          gnt, en;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t          tbl [10];
  logic          hv   [16];
  logic          hv2  [16];
  logic [DW-1:0] hd   [16];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 32'h10};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h10};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h20, 32'h30,       1'b0, 1'b1, 32'h20};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h30,       1'b1, 1'b1, 32'h30};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h0,  32'h40,       1'b1, 1'b1, 32'h40};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h50, 32'h44,       1'b0, 1'b1, 32'h50};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h44,       1'b0, 1'b0, 32'h50};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 32'h0,  32'hABCDEF01, 1'b1, 1'b1, 32'hABCDEF01};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'hABCDEF01};

    #2;
    do_reset();

    // Vector table from a fresh reset
    for (int i = 0; i < 10; i++) begin
      blank = tbl[i].blank; disp_req = tbl[i].dreq; aux_req = tbl[i].areq;
      disp_addr = tbl[i].daddr; aux_addr = tbl[i].aaddr;
      step();
      chk($sformatf("tbl%0d_gnt", i), 32'(o1_gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_en", i), 32'(o1_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_addr", i), o1_addr, tbl[i].addr);
    end
    repeat (4) step();

    // Display reads at 0,3,6: data two cycles after each request
    blank = 1'b0; aux_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      disp_req = (k < 3);
      disp_addr = (k < 3) ? AW'(3 * k) : 32'hDEAD;
      step();
      if (k < 3) chk("seq1_rom_addr", o1_addr, AW'(3 * k));
      hv[k] = o1_dv; hd[k] = o1_dd; hv2[k] = o1_av;
    end
    for (int k = 0; k < 6; k++) begin
      chk("seq1_disp_valid", 32'(hv[k]), 32'(k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) chk("seq1_disp_data", 32'(hd[k]), 32'(word(AW'(3 * (k - 2)))));
      chk("seq1_aux_valid", 32'(hv2[k]), 32'd0);
    end

    // Aux waits behind five display cycles and loses nothing
    aux_req = 1'b1; aux_addr = 32'h120;
    for (int k = 0; k < 9; k++) begin
      disp_req = (k < 5);
      disp_addr = 32'h200 + 32'(k);
      if (k >= 6) aux_req = 1'b0;
      step();
      hv[k] = o1_gnt; hv2[k] = o1_av; hd[k] = o1_ad;
    end
    for (int k = 0; k < 9; k++) begin
      chk("seq2_gnt", 32'(hv[k]), 32'(k == 5));
      chk("seq2_aux_valid", 32'(hv2[k]), 32'(k == 7));
    end
    chk("seq2_aux_data", 32'(hd[7]), 32'(word(32'h120)));

    // Burst limit during blanking: 8 grants, one gap, then grants resume
    blank = 1'b1; disp_req = 1'b0; aux_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      aux_addr = 32'h300 + 32'(k);
      step();
      hv[k] = o1_gnt;
    end
    for (int k = 0; k < 12; k++) chk("seq3_burst_gnt", 32'(hv[k]), 32'(k != 8));
    aux_req = 1'b0; blank = 1'b0;
    repeat (3) step();

    // RD_LAT=3: alternating display/aux, each word four cycles later on its own output
    for (int k = 0; k < 12; k++) begin
      disp_req = (k < 8) && (k % 2 == 0);
      aux_req = (k < 8) && (k % 2 == 1);
      disp_addr = 32'h40 + 32'(k);
      aux_addr = 32'h80 + 32'(k);
      step();
      hv[k] = o3_dv; hv2[k] = o3_av;
      hd[k] = o3_dv ? o3_dd : o3_ad;
    end
    for (int k = 4; k < 12; k++) begin
      chk("seq4_disp_valid", 32'(hv[k]), 32'((k - 4) % 2 == 0));
      chk("seq4_aux_valid", 32'(hv2[k]), 32'((k - 4) % 2 == 1));
      chk("seq4_data", 32'(hd[k]),
          32'(((k - 4) % 2 == 0) ? word(32'h40 + 32'(k - 4)) : word(32'h80 + 32'(k - 4))));
    end

    // Reset with three reads in flight: no stale strobes afterwards
    for (int k = 0; k < 3; k++) begin
      disp_req = 1'b1; disp_addr = 32'h500 + 32'(k); aux_req = 1'b0;
      step();
    end
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("seq5_no_valid", 32'(o1_dv | o1_av | o3_dv | o3_av), 32'd0);
    end

`ifdef ROM_ARB_STARVE_CNT_EN
    // 300 cycles of display starve the aux requester
    aux_req = 1'b1; aux_addr = 32'h77; disp_req = 1'b1;
    for (int k = 0; k < 300; k++) step();
    disp_req = 1'b0;
    step();
    chk("seq6_gnt", 32'(o1_gnt), 32'd1);
    chk("seq6_starve_at_gnt", 32'(o_starve), 32'd300);
    aux_req = 1'b0;
    step();
    chk("seq6_starve_after", 32'(o_starve), 32'd0);
    chk("seq6_starve_max", 32'(o_smax), 32'd300);
`endif

    // Random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      blank = 1'($urandom_range(0, 1));
      disp_req = ($urandom_range(0, 9) < 4);
      disp_addr = $urandom;
      if (aux_req && !m_gnt) begin
        if ($urandom_range(0, 19) == 0) aux_req = 1'b0;
      end else begin
        aux_req = 1'($urandom_range(0, 1));
        aux_addr = $urandom;
      end
      step();
    end
    disp_req = 1'b0; aux_req = 1'b0;
    repeat (6) step();
    chk("drain_empty", 32'(q1.size() + q3.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
